chip_prog_receiver: RTL

CHIP_PROG_RECEIVER -- requirements
Module: chip_prog_receiver

---
 rtl/chip_prog_receiver_pkg.sv | 21 ++
 rtl/sync_ff.sv | 27 ++
 rtl/chip_prog_receiver.sv | 102 ++++++++++
 3 files changed

// File: rtl/chip_prog_receiver_pkg.sv
// Shared types and constants for the serial gain-programming receiver.
package chip_prog_receiver_pkg;

    localparam int unsigned GAINA1_W      = 2;
    localparam int unsigned GAINA2_W      = 3;
    localparam int unsigned FRAME_W       = GAINA1_W + GAINA2_W;
    localparam int unsigned NBITS_DEFAULT = 5;

    typedef enum logic [1:0] {
        sIDLE  = 2'd0,
        sSHIFT = 2'd1,
        sDONE  = 2'd2
    } state_t;

    // Frame layout once fully shifted in: first bit received lands in gain_a1[0].
    typedef struct packed {
        logic [GAINA2_W-1:0] gain_a2;
        logic [GAINA1_W-1:0] gain_a1;
    } frame_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit, with selectable reset level.
module sync_ff #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= {DEPTH{RST_VAL}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[DEPTH-1];

endmodule

// File: rtl/chip_prog_receiver.sv
// Receives one LSB-first serial frame from an external programmer and latches the
// amplifier gain codes; once a full frame is applied the block is locked until reset.
module chip_prog_receiver
    import chip_prog_receiver_pkg::*;
#(
    parameter int unsigned NBITS       = NBITS_DEFAULT,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                i_mainclk,
    input  logic                i_reset,
    input  logic                i_sclk,
    input  logic                i_sdin,
    output logic [GAINA1_W-1:0] o_gainA1,
    output logic [GAINA2_W-1:0] o_gainA2,
    output logic                o_ready
);

    localparam int unsigned CNT_W = $clog2(NBITS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic               sclk_s;
    logic               sdin_s;
    logic               sclk_d;
    logic               rise;
    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    frame_t             sreg;
    logic [FRAME_W-1:0] sreg_shifted;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk (i_mainclk),
        .rst (i_reset),
        .d   (i_sclk),
        .q   (sclk_s)
    );

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sdin (
        .clk (i_mainclk),
        .rst (i_reset),
        .d   (i_sdin),
        .q   (sdin_s)
    );

    assign rise         = sclk_s & ~sclk_d;
    assign sreg_shifted = {sdin_s, sreg[FRAME_W-1:1]};

    // Frame FSM; a rise always wins over the timeout terminal count.
    always_ff @(posedge i_mainclk or posedge i_reset) begin
        if (i_reset) begin
            state    <= sIDLE;
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            sreg     <= '0;
            sclk_d   <= 1'b1;
            o_gainA1 <= '0;
            o_gainA2 <= '0;
            o_ready  <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            case (state)
                sIDLE: begin
                    if (rise) begin
                        sreg    <= frame_t'(sreg_shifted);
                        bit_cnt <= CNT_W'(1);
                        tmo_cnt <= '0;
                        state   <= sSHIFT;
                    end
                end
                sSHIFT: begin
                    if (bit_cnt == CNT_LAST) begin
                        o_gainA1 <= sreg.gain_a1;
                        o_gainA2 <= sreg.gain_a2;
                        o_ready  <= 1'b1;
                        state    <= sDONE;
                    end else if (rise) begin
                        sreg    <= frame_t'(sreg_shifted);
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        sreg    <= '0;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                        state   <= sIDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                sDONE: begin
                    state <= sDONE;
                end
                default: begin
                    state <= sIDLE;
                end
            endcase
        end
    end

endmodule
